// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared register map, control bits and glyph table for the display controller
package display_pkg;

  localparam logic [1:0] REG_LO   = 2'd0;
  localparam logic [1:0] REG_HI   = 2'd1;
  localparam logic [1:0] REG_DOTS = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_HEX   = 0;
  localparam int CTRL_BLANK = 1;
  localparam int CTRL_EN    = 2;

  localparam logic [2:0] CTRL_RESET = 3'b100;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic {
    CONV_IDLE,
    CONV_SHIFT
  } conv_state_t;

  // Active-low g..a pattern for a hex nibble
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: seg_glyph = 7'h40;
      4'h1: seg_glyph = 7'h79;
      4'h2: seg_glyph = 7'h24;
      4'h3: seg_glyph = 7'h30;
      4'h4: seg_glyph = 7'h19;
      4'h5: seg_glyph = 7'h12;
      4'h6: seg_glyph = 7'h02;
      4'h7: seg_glyph = 7'h78;
      4'h8: seg_glyph = 7'h00;
      4'h9: seg_glyph = 7'h10;
      4'hA: seg_glyph = 7'h08;
      4'hB: seg_glyph = 7'h03;
      4'hC: seg_glyph = 7'h46;
      4'hD: seg_glyph = 7'h21;
      4'hE: seg_glyph = 7'h06;
      default: seg_glyph = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/multi_digit_display_ctrl_if.sv
// rtl/multi_digit_display_ctrl_if.sv - processor bus address/strobe bundle
interface multi_digit_display_ctrl_if;
  logic [7:0] bus_addr;
  logic       bus_we;

  modport master (output bus_addr, output bus_we);
  modport slave  (input  bus_addr, input  bus_we);
endinterface

// File: rtl/bcd_dabble_seq.sv
// rtl/bcd_dabble_seq.sv - sequential double-dabble binary to BCD, one bit per clock
module bcd_dabble_seq
  import display_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [DATA_WIDTH-1:0]   i_value,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_overflow
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  conv_state_t           r_state;
  logic                  r_busy;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_acc;
  logic                  r_carry;

  logic [BW-1:0] w_adj;
  logic [BW-1:0] w_next;
  logic          w_out;
  logic          w_last;

  // Add-3 correction per digit, then shift in the next binary bit; anything
  // shifted out of the top digit means the value does not fit.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
    w_next = {w_adj[BW-2:0], r_shift[DATA_WIDTH-1]};
    w_out  = w_adj[BW-1];
    w_last = (r_cnt == CW'(DATA_WIDTH - 1));
  end

  // Conversion FSM; a new start always wins and discards any run in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CONV_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (i_start) begin
      r_state <= CONV_SHIFT;
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_shift <= i_value;
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == CONV_SHIFT) begin
      r_shift <= r_shift << 1;
      r_acc   <= w_next;
      r_carry <= r_carry | w_out;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_state <= CONV_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = (r_state == CONV_SHIFT) && w_last && !i_start;
  assign o_bcd      = w_next;
  assign o_overflow = r_carry | w_out;

endmodule

// File: rtl/multi_digit_display_ctrl.sv
// rtl/multi_digit_display_ctrl.sv - bus-mapped multiplexed N-digit 7-segment display controller
module multi_digit_display_ctrl
  import display_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'hD0,
  parameter int         NUM_DIGITS  = 4,
  parameter int         DATA_WIDTH  = 16,
  parameter int         REFRESH_DIV = 49999
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  multi_digit_display_ctrl_if.slave bus,
  inout  wire  [7:0]                io_bus_data,
  output logic [NUM_DIGITS-1:0]     o_seg_select,
  output logic [7:0]                o_dec_out
);

  localparam int         DCW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int         PW         = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1;
  localparam logic [15:0] VALUE_MASK = 16'((32'd1 << DATA_WIDTH) - 32'd1);

  logic [7:0]            r_shadow;
  logic [15:0]           r_value;
  logic [NUM_DIGITS-1:0] r_dots;
  logic [2:0]            r_ctrl;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic                  r_ovf;
  logic [PW-1:0]         r_presc;
  logic [DCW-1:0]        r_digit;

  logic [7:0]  w_off;
  logic        w_in_win;
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_reg;
  logic [15:0] w_new_value;
  logic        w_start;
  logic        w_busy;
  logic        w_done;
  logic [4*NUM_DIGITS-1:0] w_bcd;
  logic        w_ovf;
  logic [7:0]  w_rd_data;
  logic [31:0] w_src;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic        w_dash;
  logic        w_dp;
  logic [6:0]  w_seg;

  assign w_off       = bus.bus_addr - BASE_ADDR;
  assign w_in_win    = (w_off[7:2] == 6'd0);
  assign w_wr        = w_in_win & bus.bus_we;
  assign w_rd        = w_in_win & ~bus.bus_we;
  assign w_reg       = w_off[1:0];
  assign w_new_value = {io_bus_data, r_shadow} & VALUE_MASK;
  assign w_start     = w_wr && (w_reg == REG_HI);

  bcd_dabble_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_start),
    .i_value    (w_new_value[DATA_WIDTH-1:0]),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_bcd      (w_bcd),
    .o_overflow (w_ovf)
  );

  // Register file writes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= 8'h00;
      r_value  <= 16'h0000;
      r_dots   <= '0;
      r_ctrl   <= CTRL_RESET;
    end else if (w_wr) begin
      case (w_reg)
        REG_LO:   r_shadow <= io_bus_data;
        REG_HI:   r_value  <= w_new_value;
        REG_DOTS: r_dots   <= io_bus_data[NUM_DIGITS-1:0];
        default:  r_ctrl   <= io_bus_data[2:0];
      endcase
    end
  end

  // Displayed BCD only moves on a finished conversion, never mid-run
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bcd <= '0;
      r_ovf <= 1'b0;
    end else if (w_done) begin
      r_bcd <= w_bcd;
      r_ovf <= w_ovf;
    end
  end

  // Readback mux, driven onto the shared bus only for reads in our window
  always_comb begin
    w_rd_data = 8'h00;
    case (w_reg)
      REG_LO:   w_rd_data = r_value[7:0];
      REG_HI:   w_rd_data = r_value[15:8];
      REG_DOTS: w_rd_data = 8'(r_dots);
      default:  w_rd_data = {w_busy, 4'b0000, r_ctrl};
    endcase
  end

  assign io_bus_data = w_rd ? w_rd_data : 8'hzz;

  // Prescaler and digit scan counter; both run regardless of enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_digit <= '0;
    end else if (r_presc == PW'(REFRESH_DIV)) begin
      r_presc <= '0;
      r_digit <= (r_digit == DCW'(NUM_DIGITS - 1)) ? '0 : r_digit + DCW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Glyph selection for the digit being scanned: dash, blank or nibble
  always_comb begin
    w_src   = r_ctrl[CTRL_HEX] ? 32'(r_value) : 32'(r_bcd);
    w_nib   = w_src[{r_digit, 2'b00} +: 4];
    w_blank = r_ctrl[CTRL_BLANK] && (r_digit != '0) &&
              ((w_src >> {r_digit, 2'b00}) == 32'd0);
    w_dash  = !r_ctrl[CTRL_HEX] && r_ovf;
    w_dp    = r_dots[r_digit];
    w_seg   = w_dash ? SEG_DASH : (w_blank ? SEG_BLANK : seg_glyph(w_nib));
  end

  // Anode and cathode registers update together
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_seg_select <= ~NUM_DIGITS'(1);
      o_dec_out    <= {1'b1, seg_glyph(4'h0)};
    end else if (!r_ctrl[CTRL_EN]) begin
      o_seg_select <= '1;
      o_dec_out    <= 8'hFF;
    end else begin
      o_seg_select <= ~(NUM_DIGITS'(1) << r_digit);
      o_dec_out    <= {~w_dp, w_seg};
    end
  end

endmodule
